c7bifu_iq: RTL and testbench

//  Instruction queue between the fetch control/ICU return path and decode/EXU.

---
 rtl/c7bifu_iq.sv | 83 ++++++++
 tb/tb_c7bifu_iq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/c7bifu_iq.sv
// Instruction queue between the ICU return path and decode: circular FIFO of {pc, inst}
// with a throttle (iq_full) that leaves RESV slots for fetches already in flight.
module c7bifu_iq #(
   parameter int DEPTH = 8,
   parameter int RESV  = 2,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        icu_data_vld,
   input  logic [31:0] icu_ifu_data_ic2,
   input  logic [31:0] f_pc,
   input  logic        flush,
   input  logic        stall,
   output logic        iq_full,
   output logic        ifu_exu_valid_d,
   output logic [31:0] ifu_exu_inst_d,
   output logic [31:0] ifu_exu_pc_d,
   output logic        iq_ovf
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_FULL  = (AW+1)'(DEPTH - RESV);

   logic [31:0]   r_inst_mem [DEPTH];
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_ovf;

   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_pop  = (r_count != '0) & ~stall & ~flush;
   // A full queue still accepts a word when the head leaves in the same cycle.
   assign w_push = icu_data_vld & ~flush & ((r_count < LP_DEPTH) | w_pop);
   assign w_drop = icu_data_vld & ~flush & (r_count == LP_DEPTH) & ~w_pop;

   assign ifu_exu_valid_d = (r_count != '0);
   assign ifu_exu_inst_d  = r_inst_mem[r_rd_ptr];
   assign ifu_exu_pc_d    = r_pc_mem[r_rd_ptr];
   assign iq_full         = (r_count >= LP_FULL);
   assign iq_ovf          = r_ovf;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst_mem[r_wr_ptr] <= icu_ifu_data_ic2;
         r_pc_mem[r_wr_ptr]   <= f_pc;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else if (flush) begin
         // Redirect discards everything, including this cycle's wrong-path word.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push & ~w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop & ~w_push) begin
            r_count <= r_count - (AW+1)'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_c7bifu_iq.sv
// Scoreboard bench for c7bifu_iq: a queue-based reference model tracks accepted words,
// a negedge monitor compares the DUT head, valid, full and overflow flags against it.
module tb_c7bifu_iq;

   localparam int DEPTH = 8;
   localparam int RESV  = 2;

   logic        clk;
   logic        resetn;
   logic        icu_data_vld;
   logic [31:0] icu_ifu_data_ic2;
   logic [31:0] f_pc;
   logic        flush;
   logic        stall;
   logic        iq_full;
   logic        ifu_exu_valid_d;
   logic [31:0] ifu_exu_inst_d;
   logic [31:0] ifu_exu_pc_d;
   logic        iq_ovf;

   c7bifu_iq #(.DEPTH(DEPTH), .RESV(RESV), .AW(3)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .icu_data_vld     (icu_data_vld),
      .icu_ifu_data_ic2 (icu_ifu_data_ic2),
      .f_pc             (f_pc),
      .flush            (flush),
      .stall            (stall),
      .iq_full          (iq_full),
      .ifu_exu_valid_d  (ifu_exu_valid_d),
      .ifu_exu_inst_d   (ifu_exu_inst_d),
      .ifu_exu_pc_d     (ifu_exu_pc_d),
      .iq_ovf           (iq_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] exp_q[$];
   bit          m_ovf;
   int          n_total;
   int          n_pass;
   logic [31:0] pc_next;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Reference model: queue semantics from the behavioural rules, updated on each edge.
   initial begin
      exp_q.delete();
      m_ovf = 1'b0;
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            exp_q.delete();
            m_ovf = 1'b0;
         end else if (flush) begin
            exp_q.delete();
         end else begin
            bit do_pop;
            do_pop = (exp_q.size() != 0) && !stall;
            if (icu_data_vld) begin
               if (exp_q.size() < DEPTH || do_pop) begin
                  if (do_pop) void'(exp_q.pop_front());
                  exp_q.push_back({f_pc, icu_ifu_data_ic2});
                  do_pop = 1'b0;
               end else begin
                  m_ovf = 1'b1;
               end
            end
            if (do_pop) void'(exp_q.pop_front());
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("valid", 32'(ifu_exu_valid_d), 32'(exp_q.size() != 0));
         chk("iq_full", 32'(iq_full), 32'(exp_q.size() >= DEPTH - RESV));
         chk("iq_ovf", 32'(iq_ovf), 32'(m_ovf));
         if (exp_q.size() != 0) begin
            chk("head_inst", ifu_exu_inst_d, exp_q[0][31:0]);
            chk("head_pc", ifu_exu_pc_d, exp_q[0][63:32]);
         end
      end
   end

   task automatic cyc(input bit v, input bit s, input bit f);
      icu_data_vld     = v;
      icu_ifu_data_ic2 = $urandom;
      f_pc             = pc_next;
      stall            = s;
      flush            = f;
      if (v) pc_next = pc_next + 32'd4;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      icu_data_vld = 1'b0;
      stall        = 1'b0;
      flush        = 1'b0;
      resetn       = 1'b0;
      #1;
      chk("rst_valid", 32'(ifu_exu_valid_d), 32'd0);
      chk("rst_full", 32'(iq_full), 32'd0);
      chk("rst_ovf", 32'(iq_ovf), 32'd0);
      @(posedge clk);
      #1;
      resetn  = 1'b1;
      pc_next = 32'h1C00_0000;
   endtask

   initial begin
      n_total          = 0;
      n_pass           = 0;
      resetn           = 1'b0;
      icu_data_vld     = 1'b0;
      icu_ifu_data_ic2 = '0;
      f_pc             = '0;
      flush            = 1'b0;
      stall            = 1'b0;
      pc_next          = 32'h1C00_0000;
      @(posedge clk);
      #1;
      do_reset();

      // Three words in order, then drain.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);

      // Stalled fill past the throttle, up to full, then one overflowing push.
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);

      // Full queue with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);

      // Flush with a wrong-path word, then the first post-flush push.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("flush_valid", 32'(ifu_exu_valid_d), 32'd0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);

      // Wrap-around with steady push and pop.
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);

      // Asynchronous reset while holding four words.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 10) < 6, ($urandom % 10) < 4, ($urandom % 20) == 0);
      end
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
